// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// Owns the F-stage PC register. The unit fetches the instruction at f_pc from
// instruction memory over a req/ack handshake, then holds the word for the
// D stage until D accepts it. On acceptance the unit loads npc and starts the
// next fetch. Memory latency can vary. Only one request is outstanding at a
// time. f_busy tells the hazard unit to freeze F/D while a fetch is in flight.
//
// Optional feature: FETCH_ALIGN_CHECK_EN
//   Defined:   misaligned or out-of-window fetch addresses issue no request.
//              They deliver a nop with f_exc_adel=1.
//   Undefined: every address is requested and f_exc_adel is tied to 0.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high
//   npc         in   32  next PC, sampled only when D accepts the held entry
//   stall       in   1   1 = D does not accept the held entry
//   imem_req    out  1   fetch request, held until imem_ack
//   imem_addr   out  32  fetch address (= f_pc)
//   imem_ack    in   1   imem_rdata valid this cycle
//   imem_rdata  in   32  instruction word
//   f_pc        out  32  PC of the held instruction
//   f_instr     out  32  held instruction word
//   f_valid     out  1   f_pc/f_instr valid for D
//   f_busy      out  1   fetch in flight
//   f_exc_adel  out  1   fetch address error on the held entry
//   fetch_cnt   out  32  entries accepted by D since reset (wraps)
// ---------------------------------------------------------------------------
// state  | meaning
// S_BOOT | one idle cycle after reset release, no request
// S_REQ  | fetch in flight for f_pc, waiting for imem_ack
// S_FULL | instruction held for D, waiting for !stall
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_valid,
    output logic        f_busy,
    output logic        f_exc_adel,
    output logic [31:0] fetch_cnt
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0] state;
    logic       addr_ok;

`ifdef FETCH_ALIGN_CHECK_EN
    logic [32:0] win_end;

    // The window end is computed at 33 bits so that a window reaching the top
    // of the address space does not wrap.
    assign win_end = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
    assign addr_ok = (f_pc[1:0] == 2'b00) && (f_pc >= IMEM_BASE) &&
                     ({1'b0, f_pc} < win_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_exc_adel <= 1'b0;
        end else if (state == S_REQ && !addr_ok) begin
            f_exc_adel <= 1'b1;
        end else if (state == S_FULL && !stall) begin
            f_exc_adel <= 1'b0;
        end
    end
`else
    logic unused_window;

    assign addr_ok       = 1'b1;
    assign unused_window = ^{IMEM_BASE, IMEM_SIZE};
    assign f_exc_adel    = 1'b0;
`endif

    // The request is decoded from the state register. Because of that, an
    // asynchronous reset drops it at once, without waiting for a clock edge.
    assign imem_req  = (state == S_REQ) && addr_ok;
    assign imem_addr = f_pc;
    assign f_busy    = (state == S_REQ);
    assign f_valid   = (state == S_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_BOOT;
            f_pc      <= RESET_PC;
            f_instr   <= '0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (!addr_ok) begin
                        // A rejected address delivers a nop instead of a fetch.
                        f_instr <= '0;
                        state   <= S_FULL;
                    end else if (imem_ack) begin
                        f_instr <= imem_rdata;
                        state   <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        f_pc      <= npc;
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= S_REQ;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] npc = '0;
    logic        stall = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_busy;
    logic        f_exc_adel;
    logic [31:0] fetch_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;

    // reference model state: the PC the held entry should carry and accept count
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_cnt = '0;

    // memory responder controls
    int          mem_lat = 1;
    int          lat_cnt = 0;
    int          spur_req = 0;
    int          spur_done = 0;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .npc(npc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .f_pc(f_pc), .f_instr(f_instr),
        .f_valid(f_valid), .f_busy(f_busy), .f_exc_adel(f_exc_adel),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2402_0001;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // Memory model: acks on the mem_lat-th cycle that a request is seen.
    // A spurious ack can be injected into any cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (reset || imem_req !== 1'b1) begin
                lat_cnt = 0;
            end else begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    lat_cnt    = 0;
                end
            end
            if (spur_req != spur_done) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                spur_done  = spur_req;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // D accepts the held entry with next PC n. This updates the model.
    task automatic accept(input logic [31:0] n);
        npc   = n;
        stall = 1'b0;
        step();
        stall   = 1'b1;
        npc     = $urandom;
        exp_pc  = n;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    // Waits (bounded) for f_valid and records the request address behaviour.
    task automatic wait_valid(output int cycles, output logic [31:0] addr,
                              output bit moved, output bit timeout);
        bit seen;
        seen = 0; cycles = 0; addr = '0; moved = 0;
        while (f_valid !== 1'b1 && cycles < 50) begin
            if (imem_req === 1'b1) begin
                if (seen && imem_addr !== addr) moved = 1;
                addr = imem_addr;
                seen = 1;
            end
            step();
            cycles++;
        end
        timeout = (f_valid !== 1'b1);
    endtask

    task automatic test_reset();
        int cyc; logic [31:0] a; bit mv, to;
        mem_lat = 1;
        step();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_cmp++; if (f_valid !== 1'b0 || f_busy !== 1'b0) begin n_bad++; $display("FAIL reset_valid_busy got %b%b want 00", f_valid, f_busy); end
        n_cmp++; if (f_pc !== RESET_PC || fetch_cnt !== 32'd0 || f_instr !== 32'd0) begin n_bad++; $display("FAIL reset_regs got pc=%h cnt=%0d instr=%h want pc=%h cnt=0 instr=0", f_pc, fetch_cnt, f_instr, RESET_PC); end
        n_cmp++; if (f_exc_adel !== 1'b0) begin n_bad++; $display("FAIL reset_exc got %b want 0", f_exc_adel); end
        reset = 1'b0;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL boot_idle_req got %b want 0", imem_req); end
        wait_valid(cyc, a, mv, to);
        n_cmp++; if (to || cyc != 2) begin n_bad++; $display("FAIL first_fetch_latency got %0d cycles (timeout=%0d) want 2", cyc, to); end
        n_cmp++; if (a !== RESET_PC) begin n_bad++; $display("FAIL first_fetch_addr got %h want %h", a, RESET_PC); end
        n_cmp++; if (f_instr !== 32'h2402_0001 || f_pc !== RESET_PC) begin n_bad++; $display("FAIL first_fetch_data got %h@%h want 24020001@%h", f_instr, f_pc, RESET_PC); end
    endtask

    task automatic test_sequential();
        int cyc; logic [31:0] a; bit mv, to;
        mem_lat = 3;
        for (int i = 0; i < 3; i++) begin
            accept(exp_pc + 32'd4);
            wait_valid(cyc, a, mv, to);
            n_cmp++; if (to || cyc != 3) begin n_bad++; $display("FAIL seq_latency[%0d] got %0d want 3", i, cyc); end
            n_cmp++; if (a !== exp_pc || mv) begin n_bad++; $display("FAIL seq_addr[%0d] got %h moved=%0d want %h", i, a, mv, exp_pc); end
            n_cmp++; if (f_pc !== exp_pc || f_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL seq_entry[%0d] got %h/%h want %h/%h", i, f_pc, f_instr, exp_pc, mem_word(exp_pc)); end
        end
        n_cmp++; if (fetch_cnt !== exp_cnt) begin n_bad++; $display("FAIL seq_fetch_cnt got %0d want %0d", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_stall();
        int cyc; logic [31:0] a; bit mv, to;
        mem_lat = 2;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            npc = $urandom;
            step();
            n_cmp++; if (f_pc !== exp_pc || f_instr !== mem_word(exp_pc) || f_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold[%0d] got %h/%h v=%b want %h/%h v=1", i, f_pc, f_instr, f_valid, exp_pc, mem_word(exp_pc)); end
            n_cmp++; if (imem_req !== 1'b0 || f_busy !== 1'b0) begin n_bad++; $display("FAIL stall_no_req[%0d] got req=%b busy=%b want 0", i, imem_req, f_busy); end
        end
        accept(32'h0000_3100);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3100 || f_busy !== 1'b1) begin n_bad++; $display("FAIL stall_release got req=%b addr=%h busy=%b want 1/00003100/1", imem_req, imem_addr, f_busy); end
        wait_valid(cyc, a, mv, to);
        n_cmp++; if (to || f_instr !== mem_word(32'h0000_3100) || cyc != 2) begin n_bad++; $display("FAIL stall_release_fetch got %h in %0d want %h in 2", f_instr, cyc, mem_word(32'h0000_3100)); end
    endtask

    task automatic test_branch_spurious();
        int cyc; logic [31:0] a; bit mv, to;
        mem_lat = 1;
        spur_req++;
        step();
        step();
        n_cmp++; if (f_instr !== mem_word(exp_pc) || f_valid !== 1'b1) begin n_bad++; $display("FAIL spurious_ack got %h v=%b want %h v=1", f_instr, f_valid, mem_word(exp_pc)); end
        accept(32'h0000_3040);
        n_cmp++; if (imem_addr !== 32'h0000_3040 || imem_req !== 1'b1) begin n_bad++; $display("FAIL branch_addr got %h req=%b want 00003040 req=1", imem_addr, imem_req); end
        wait_valid(cyc, a, mv, to);
        n_cmp++; if (to || f_pc !== 32'h0000_3040 || f_instr !== mem_word(32'h0000_3040)) begin n_bad++; $display("FAIL branch_entry got %h/%h want 00003040/%h", f_pc, f_instr, mem_word(32'h0000_3040)); end
    endtask

    task automatic test_random();
        int cyc; logic [31:0] a; bit mv, to; logic [31:0] n; int hold;
        for (int i = 0; i < 24; i++) begin
            mem_lat = $urandom_range(1, 4);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                npc = $urandom;
                step();
            end
            n = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
`ifndef FETCH_ALIGN_CHECK_EN
            n[1:0] = 2'($urandom_range(0, 3));
`endif
            accept(n);
            wait_valid(cyc, a, mv, to);
            n_cmp++; if (to || cyc != mem_lat) begin n_bad++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, cyc, mem_lat); end
            n_cmp++; if (a !== n || mv || f_pc !== n || f_instr !== mem_word(n)) begin n_bad++; $display("FAIL rand_entry[%0d] got addr=%h pc=%h instr=%h want %h/%h", i, a, f_pc, f_instr, n, mem_word(n)); end
            n_cmp++; if (fetch_cnt !== exp_cnt || f_exc_adel !== 1'b0) begin n_bad++; $display("FAIL rand_cnt[%0d] got %0d exc=%b want %0d exc=0", i, fetch_cnt, f_exc_adel, exp_cnt); end
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        int cyc; logic [31:0] a; bit mv, to;
        logic [31:0] bad [3];
        bad[0] = 32'h0000_3002; bad[1] = 32'h0000_1000; bad[2] = 32'h0000_7000;
        mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            accept(bad[i]);
            n_cmp++; if (imem_req !== 1'b0 || f_valid !== 1'b0 || f_exc_adel !== 1'b0) begin n_bad++; $display("FAIL adel_req[%0d] got req=%b v=%b exc=%b want 0/0/0", i, imem_req, f_valid, f_exc_adel); end
            step();
            n_cmp++; if (f_valid !== 1'b1 || f_instr !== 32'd0 || f_exc_adel !== 1'b1 || f_pc !== bad[i]) begin n_bad++; $display("FAIL adel_entry[%0d] got v=%b instr=%h exc=%b pc=%h want 1/0/1/%h", i, f_valid, f_instr, f_exc_adel, f_pc, bad[i]); end
        end
        accept(32'h0000_6FFC);
        wait_valid(cyc, a, mv, to);
        n_cmp++; if (to || f_exc_adel !== 1'b0 || f_instr !== mem_word(32'h0000_6FFC)) begin n_bad++; $display("FAIL adel_clear got exc=%b instr=%h want 0/%h", f_exc_adel, f_instr, mem_word(32'h0000_6FFC)); end
    endtask
`else
    task automatic test_unaligned_pass();
        int cyc; logic [31:0] a; bit mv, to;
        mem_lat = 1;
        accept(32'h0000_3002);
        wait_valid(cyc, a, mv, to);
        n_cmp++; if (to || a !== 32'h0000_3002 || f_instr !== mem_word(32'h0000_3002) || f_exc_adel !== 1'b0) begin n_bad++; $display("FAIL unaligned_pass got addr=%h instr=%h exc=%b want 00003002/%h/0", a, f_instr, f_exc_adel, mem_word(32'h0000_3002)); end
    endtask
`endif

    task automatic test_reset_midfetch();
        int cyc; logic [31:0] a; bit mv, to;
        mem_lat = 100;
        accept(32'h0000_3200);
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL midfetch_req got %b want 1", imem_req); end
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || f_busy !== 1'b0 || f_valid !== 1'b0) begin n_bad++; $display("FAIL midfetch_async_drop got req=%b busy=%b v=%b want 0", imem_req, f_busy, f_valid); end
        n_cmp++; if (f_pc !== RESET_PC || fetch_cnt !== 32'd0) begin n_bad++; $display("FAIL midfetch_regs got pc=%h cnt=%0d want %h/0", f_pc, fetch_cnt, RESET_PC); end
        step();
        mem_lat = 1;
        spur_req++;
        step();
        reset = 1'b0;
        exp_pc = RESET_PC;
        exp_cnt = '0;
        wait_valid(cyc, a, mv, to);
        n_cmp++; if (to || cyc != 2 || a !== RESET_PC) begin n_bad++; $display("FAIL restart got %0d cycles addr=%h want 2/%h", cyc, a, RESET_PC); end
        n_cmp++; if (f_instr !== 32'h2402_0001 || f_pc !== RESET_PC || fetch_cnt !== 32'd0) begin n_bad++; $display("FAIL stale_ack got %h@%h cnt=%0d want 24020001@%h cnt=0", f_instr, f_pc, fetch_cnt, RESET_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_spurious();
        test_random();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`else
        test_unaligned_pass();
`endif
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
